// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU share arbiter: ALU operation codes and
// FSM state encodings.
package alu_ctrl_pkg;

  // ALU control encodings (2-bit control into the external ALU)
  localparam logic [1:0] ALU_AND  = 2'b00;
  localparam logic [1:0] ALU_OR   = 2'b01;
  localparam logic [1:0] ALU_ADD  = 2'b10;
  localparam logic [1:0] ALU_NAND = 2'b11;

  // Arbiter FSM: accept a request, let the ALU settle, hold the response
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage : alu_ctrl_pkg

// File: rtl/rr_grant.sv
// Combinational round-robin picker: returns the first requester whose valid
// bit is set at or after the pointer, wrapping modulo NUM_REQ.
module rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   owner_o,
  output logic               valid_o
);

  logic [PTR_W:0] sum;

  // Scan from the pointer outward and keep only the first requester found
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_o = '0;
    owner_o = '0;
    valid_o = 1'b0;
    sum     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      if (!valid_o && req_i[sum[PTR_W-1:0]]) begin
        grant_o[sum[PTR_W-1:0]] = 1'b1;
        owner_o                 = sum[PTR_W-1:0];
        valid_o                 = 1'b1;
      end
    end
  end

endmodule : rr_grant

// File: rtl/alu_share_arbiter.sv
// Shares one external 32-bit ALU between NUM_REQ requesters. One operation is
// in flight at a time: IDLE accepts the round-robin winner, EXEC captures the
// ALU result, RESP presents it to the owner until it is taken.
// Optional feature: define ALU_ARB_ZERO_FLAG_EN to add the RespZero output.
module alu_share_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  input  logic [NUM_REQ-1:0]       ReqValid,
  output logic [NUM_REQ-1:0]       ReqReady,
  input  logic [NUM_REQ*WIDTH-1:0] ReqOpA,
  input  logic [NUM_REQ*WIDTH-1:0] ReqOpB,
  input  logic [NUM_REQ*2-1:0]     ReqCtrl,
  output logic [NUM_REQ-1:0]       RespValid,
  input  logic [NUM_REQ-1:0]       RespReady,
  output logic [WIDTH-1:0]         RespResult,
`ifdef ALU_ARB_ZERO_FLAG_EN
  output logic                     RespZero,
`endif
  output logic [WIDTH-1:0]         ALUInA,
  output logic [WIDTH-1:0]         ALUInB,
  output logic [1:0]               ALUControlSignal,
  input  logic [WIDTH-1:0]         ALUResult
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   result_q, result_d;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic               zero_q, zero_d;
`endif

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_owner;
  logic               grant_valid;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_grant (
    .req_i   (ReqValid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .owner_o (grant_owner),
    .valid_o (grant_valid)
  );

  // Next-state, datapath capture and handshake outputs for the 3-state FSM
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    ctrl_d    = ctrl_q;
    result_d  = result_q;
`ifdef ALU_ARB_ZERO_FLAG_EN
    zero_d    = zero_q;
`endif
    ReqReady  = '0;
    RespValid = '0;

    unique case (state_q)
      IDLE: begin
        // Ready follows the winner directly, so any valid request handshakes now
        ReqReady = grant;
        if (grant_valid) begin
          owner_d = grant_owner;
          op_a_d  = ReqOpA[int'(grant_owner)*WIDTH +: WIDTH];
          op_b_d  = ReqOpB[int'(grant_owner)*2*WIDTH/2 +: WIDTH];
          ctrl_d  = ReqCtrl[int'(grant_owner)*2 +: 2];
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = ALUResult;
`ifdef ALU_ARB_ZERO_FLAG_EN
        zero_d   = (ALUResult == '0);
`endif
        state_d  = RESP;
      end
      RESP: begin
        RespValid[owner_q] = 1'b1;
        // Ready bits of other requesters are ignored
        if (RespReady[owner_q]) begin
          ptr_d   = (owner_q == PTR_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      ctrl_q   <= ALU_AND;
      result_q <= '0;
`ifdef ALU_ARB_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
`ifdef ALU_ARB_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign ALUInA           = op_a_q;
  assign ALUInB           = op_b_q;
  assign ALUControlSignal = ctrl_q;
  assign RespResult       = result_q;
`ifdef ALU_ARB_ZERO_FLAG_EN
  assign RespZero         = zero_q;
`endif

endmodule : alu_share_arbiter
